pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Detects load-use hazards.
- Flushes wrong-path instructions on a taken branch resolved in EX.
- Freezes the pipeline while a multi-cycle data-memory access issued from the EX/MEM stage is outstanding.
- Enforces a watchdog timeout on that access.

---
 rtl/pipe_ctrl_pkg.sv | 10 +
 rtl/pipe_wait_timer.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 85 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared widths, memory-control bit positions and FSM state type for the pipeline controller
// Contents: REG_ADDR_W, MEM_CTRL_W, MEM_RD_BIT/MEM_WR_BIT/MEM_SZ_BIT, state_t {RUN, MEM_WAIT}
package pipe_ctrl_pkg;
    localparam int REG_ADDR_W = 3;
    localparam int MEM_CTRL_W = 3;
    localparam int MEM_RD_BIT = 0;
    localparam int MEM_WR_BIT = 1;
    localparam int MEM_SZ_BIT = 2;
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
endpackage

// File: rtl/pipe_wait_timer.sv
// pipe_wait_timer: memory-wait cycle counter with load-to-1, clear and increment, flags wait_cnt == MAX_WAIT
// Ports: clk, rst_n (async active-low), load_i (cnt <= 1), clr_i (cnt <= 0), inc_i (cnt++),
//        timeout_o (cnt equals MAX_WAIT)
module pipe_wait_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic timeout_o
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign cnt_d = clr_i ? '0 : load_i ? CW'(1) : inc_i ? cnt_q + CW'(1) : cnt_q;
    assign timeout_o = cnt_q == CW'(MAX_WAIT);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for load-use, taken-branch and multi-cycle memory-wait hazards
// Ports: clk, rst_n (async active-low);
//        id_rs1_i/id_rs2_i (ID sources), idex_rd_i/idex_mem_read_i (ID/EX load dest),
//        exmem_mem_ctrl_i (bit0 read, bit1 write, bit2 size), mem_ready_i, branch_taken_i;
//        pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o, exmem_en_o, memwb_bubble_o (Mealy),
//        mem_err_o (registered timeout pulse), stall_cycles_o (perf counter).
// Build option: define PIPE_PERF_CNT_EN to instantiate the saturating stall-cycle counter;
//               otherwise stall_cycles_o is tied to zero.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] idex_rd_i,
    input  logic                  idex_mem_read_i,
    input  logic [MEM_CTRL_W-1:0] exmem_mem_ctrl_i,
    input  logic                  mem_ready_i,
    input  logic                  branch_taken_i,
    output logic                  pc_en_o,
    output logic                  ifid_en_o,
    output logic                  ifid_flush_o,
    output logic                  idex_en_o,
    output logic                  idex_flush_o,
    output logic                  exmem_en_o,
    output logic                  memwb_bubble_o,
    output logic                  mem_err_o,
    output logic [31:0]           stall_cycles_o
);
    state_t state_q, state_d;
    logic mem_err_q;
    logic mem_access, load_use, timeout, in_wait;
    logic stall_run, hold, abort, freeze, br, lu;
    logic unused_size;
    assign unused_size = exmem_mem_ctrl_i[MEM_SZ_BIT];
    assign mem_access = exmem_mem_ctrl_i[MEM_RD_BIT] | exmem_mem_ctrl_i[MEM_WR_BIT];
    assign load_use = idex_mem_read_i & (idex_rd_i == id_rs1_i | idex_rd_i == id_rs2_i);
    assign in_wait = state_q == MEM_WAIT;
    assign stall_run = !in_wait & mem_access & !mem_ready_i;
    assign hold = in_wait & !mem_ready_i & !timeout;
    assign abort = in_wait & !mem_ready_i & timeout;
    assign freeze = stall_run | hold;
    // Branch outranks load-use: its flush already kills the dependent instruction.
    assign br = !in_wait & !stall_run & branch_taken_i;
    assign lu = !in_wait & !stall_run & !branch_taken_i & load_use;
    // Outputs are forced low while reset is held, independent of state.
    assign pc_en_o = rst_n & !freeze & !lu;
    assign ifid_en_o = rst_n & !freeze & !lu;
    assign idex_en_o = rst_n & !freeze;
    assign exmem_en_o = rst_n & !freeze;
    assign ifid_flush_o = rst_n & br;
    assign idex_flush_o = rst_n & (br | lu);
    assign memwb_bubble_o = rst_n & (freeze | abort);
    assign mem_err_o = mem_err_q;
    assign state_d = stall_run ? MEM_WAIT : (in_wait & (mem_ready_i | timeout)) ? RUN : state_q;
    pipe_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (stall_run),
        .clr_i    (in_wait & (mem_ready_i | timeout)),
        .inc_i    (hold),
        .timeout_o(timeout)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= RUN;
            mem_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_err_q <= abort;
        end
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    assign stall_d = (!pc_en_o && stall_q != 32'hFFFF_FFFF) ? stall_q + 32'd1 : stall_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) stall_q <= '0;
        else stall_q <= stall_d;
    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus randomized checks of pipe_hazard_ctrl against a cycle-level reference model
module tb_pipe_hazard_ctrl;
    localparam int MW = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [2:0] id_rs1 = '0, id_rs2 = '0, idex_rd = '0, exmem_mem_ctrl = '0;
    logic idex_mem_read = 1'b0, mem_ready = 1'b0, branch_taken = 1'b0;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, mem_err;
    logic [31:0] stall_cycles;
    int tests = 0, fails = 0;
    bit m_busy = 0, m_err = 0;
    int m_waited = 0;
    longint m_stalls = 0;

    pipe_hazard_ctrl #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .idex_rd_i(idex_rd), .idex_mem_read_i(idex_mem_read),
        .exmem_mem_ctrl_i(exmem_mem_ctrl), .mem_ready_i(mem_ready), .branch_taken_i(branch_taken),
        .pc_en_o(pc_en), .ifid_en_o(ifid_en), .ifid_flush_o(ifid_flush), .idex_en_o(idex_en),
        .idex_flush_o(idex_flush), .exmem_en_o(exmem_en), .memwb_bubble_o(memwb_bubble),
        .mem_err_o(mem_err), .stall_cycles_o(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_stalls();
`ifdef PIPE_PERF_CNT_EN
        return (m_stalls > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_stalls);
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_all(input string tag, input logic [6:0] e);
        chk({tag, ".ctl"}, {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble}, e);
        chk({tag, ".err"}, mem_err, m_err);
        chk({tag, ".perf"}, stall_cycles, exp_stalls());
    endtask

    // One clock cycle: drive at posedge+1, check at posedge+4, advance model at the edge.
    // Expected vector order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en memwb_bubble.
    task automatic step(input string tag, input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                        input logic mr, input logic [2:0] mc, input logic rdy, input logic br);
        logic [6:0] e;
        bit acc, lu, err_next;
        id_rs1 = rs1; id_rs2 = rs2; idex_rd = rd; idex_mem_read = mr;
        exmem_mem_ctrl = mc; mem_ready = rdy; branch_taken = br;
        acc = mc[0] | mc[1];
        lu = mr && (rd == rs1 || rd == rs2);
        err_next = 0;
        e = 7'b1101010;
        if (!m_busy) begin
            if (acc && !rdy) e = 7'b0000001;
            else if (br) e = 7'b1111110;
            else if (lu) e = 7'b0001110;
        end else if (!rdy) begin
            e = (m_waited == MW) ? 7'b1101011 : 7'b0000001;
        end
        #3;
        check_all(tag, e);
        @(posedge clk);
        if (!m_busy) begin
            if (acc && !rdy) begin m_busy = 1; m_waited = 1; end
        end else if (rdy) begin
            m_busy = 0; m_waited = 0;
        end else if (m_waited == MW) begin
            m_busy = 0; m_waited = 0; err_next = 1;
        end else m_waited++;
        m_err = err_next;
        if (!e[6]) m_stalls++;
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 3'd1, 3'd2, 3'd0, 1'b0, 3'b000, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle with random inputs, released just after an edge.
    task automatic do_reset(input string tag, input int cycles);
        {id_rs1, id_rs2, idex_rd} = 9'($urandom);
        {idex_mem_read, mem_ready, branch_taken} = 3'($urandom);
        exmem_mem_ctrl = 3'($urandom);
        #1 rst_n = 1'b0;
        m_busy = 0; m_waited = 0; m_err = 0; m_stalls = 0;
        #1;
        check_all(tag, 7'b0000000);
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1;
        do_reset("reset", 2);
        idle("post_reset");
        idle("idle");
        step("loaduse", 3'd5, 3'd3, 3'd3, 1'b1, 3'b000, 1'b0, 1'b0);
        step("loaduse_clear", 3'd5, 3'd3, 3'd3, 1'b0, 3'b000, 1'b0, 1'b0);
        step("loaduse_rs1_zero", 3'd0, 3'd6, 3'd0, 1'b1, 3'b000, 1'b0, 1'b0);
        step("load_nomatch", 3'd1, 3'd2, 3'd4, 1'b1, 3'b000, 1'b0, 1'b0);
        step("ready_first", 3'd1, 3'd2, 3'd0, 1'b0, 3'b001, 1'b1, 1'b0);
        step("size_only", 3'd1, 3'd2, 3'd0, 1'b0, 3'b100, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("memwait", 3'd1, 3'd2, 3'd0, 1'b0, 3'b001, 1'b0, 1'b0);
        step("mem_release", 3'd1, 3'd2, 3'd0, 1'b0, 3'b001, 1'b1, 1'b0);
        idle("after_release");
        for (int i = 0; i < MW + 1; i++) step("timeout", 3'd1, 3'd2, 3'd0, 1'b0, 3'b010, 1'b0, 1'b0);
        idle("mem_err_pulse");
        idle("mem_err_clear");
        step("br_and_lu", 3'd4, 3'd1, 3'd4, 1'b1, 3'b000, 1'b0, 1'b1);
        step("br_during_wait0", 3'd1, 3'd2, 3'd0, 1'b0, 3'b001, 1'b0, 1'b1);
        step("br_during_wait1", 3'd4, 3'd2, 3'd4, 1'b1, 3'b001, 1'b0, 1'b1);
        step("wait_release2", 3'd1, 3'd2, 3'd0, 1'b0, 3'b001, 1'b1, 1'b0);
        step("mem_over_br", 3'd1, 3'd2, 3'd0, 1'b0, 3'b011, 1'b0, 1'b1);
        step("wait_before_rst", 3'd1, 3'd2, 3'd0, 1'b0, 3'b011, 1'b0, 1'b0);
        do_reset("reset_midwait", 1);
        for (int i = 0; i < 3; i++) idle("post_rst_idle");
        for (int i = 0; i < MW + 1; i++) step("full_timeout", 3'd1, 3'd2, 3'd0, 1'b0, 3'b001, 1'b0, 1'b0);
        idle("full_timeout_err");
        for (int i = 0; i < 400; i++) begin
            logic [2:0] mc;
            mc = ($urandom % 2 == 0) ? 3'b000 : 3'($urandom);
            step("rand", 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                 mc, ($urandom % 4) == 0, ($urandom % 4) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
